modmul_front: RTL and testbench
===============================

// Module: modmul_front
// PURPOSE
//  Upstream sequencer for the Barrett reduction stage in the multiplier pool.
//  Accepts an operand pair plus modulus over a valid/ready handshake and forms
//  the full 2*NBITS product with an iterative digit-serial multiplier.
//  Launches the reducer with a one-cycle start pulse, then captures its result.
//  Presents the reduced residue downstream over a valid/ready handshake.
// PARAMETERS
//  NBITS  128  operand and modulus width; the product is 2*NBITS
//  DBITS  32   multiplier digit width; NBITS % DBITS == 0, NDIG = NBITS/DBITS
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  rst        in   1         asynchronous reset, active-high
//  in_valid   in   1         operand set valid
//  in_ready   out  1         block can accept an operand set
//  opa        in   NBITS     multiplicand
//  opb        in   NBITS     multiplier
//  m          in   NBITS     modulus for this operation
//  red_start  out  1         one-cycle start pulse to the reducer
//  red_a      out  2*NBITS   product opa*opb, driven to the reducer
//  red_m      out  NBITS     latched modulus, driven to the reducer
//  red_mx3    out  NBITS+2   3*m, latched at accept
//  red_done   in   1         reducer result-valid pulse
//  red_y      in   NBITS     reducer result, sampled when red_done=1
//  out_valid  out  1         result valid
//  out_ready  in   1         downstream accepts the result
//  out_y      out  NBITS     reduced result (opa*opb mod m)
//  busy       out  1         high in every state except IDLE
// BEHAVIOUR
//  Reset values: all outputs 0 except in_ready=1; all internal registers 0;
//   FSM in IDLE.
//  FSM states: IDLE, MULT, RED, HOLD.
//  IDLE:
//   - in_ready=1.
//   - On edge with in_valid=1: latch opa, opb, m and red_mx3=(m<<1)+m;
//     clear acc[2*NBITS-1:0]; set cnt=0; go to MULT.
//  MULT:
//   - Digits of opb are consumed MS-first.
//   - Each edge: acc <= (acc<<DBITS) + opa*opb_digit[NDIG-1-cnt]; cnt++.
//   - acc width is exactly 2*NBITS. No overflow is possible.
//   - After NDIG edges: red_a<=acc (final value), red_start<=1, go to RED.
//  RED:
//   - red_start is high for exactly one cycle, the first cycle of RED.
//   - Stay in RED until red_done=1 is sampled.
//   - On that edge: out_y<=red_y, out_valid<=1, go to HOLD.
//   - red_done and red_start may coincide only with a 0-latency reducer;
//     such a reducer is unsupported.
//  HOLD:
//   - out_valid=1; out_y stable.
//   - On edge with out_ready=1: out_valid<=0, go to IDLE.
//  Stability: red_a, red_m and red_mx3 are held stable from red_start until
//   the next accept. out_y is held until the next capture.
//  Latency: accept edge T -> red_start high in cycle after T+NDIG.
//   With the 3-cycle reducer, red_done is sampled at edge T+NDIG+4 and
//   out_valid rises after edge T+NDIG+4. With NDIG=4, out_valid is visible
//   8 cycles after accept.
//  Throughput: one op in flight. in_ready=0 outside IDLE; in_valid there is
//   ignored (not latched).
//  Boundary conditions:
//   - red_done outside RED: ignored.
//   - out_ready while not in HOLD: ignored.
//   - out_ready held high: HOLD lasts exactly one cycle.
//   - Zero operands: product 0; the FSM still runs the full sequence.
//   - rst asserted mid-operation: immediate return to IDLE with reset values.
//     A later red_done from the aborted op is ignored (arrives in IDLE).
// TESTING
//  All scenarios use NBITS=128, DBITS=32 and a behavioural 3-cycle Barrett model.
//  1 opa=3, opb=5, m=7 -> red_a=15, red_mx3=21, single red_start pulse;
//    out_y=1; out_valid visible 8 cycles after accept.
//  2 opa=opb=2^128-1, m=2^127-1 -> red_a=2^256-2^129+1 (exact);
//    out_y matches the golden mod.
//  3 out_ready=0 for 10 cycles after out_valid -> out_y/out_valid stable,
//    in_ready=0, busy=1; release -> IDLE next cycle.
//  4 in_valid pulsed during MULT and RED with other operands -> no effect;
//    result equals the first op only.
//  5 rst at cycle 2 of MULT -> all outputs at reset values; reducer's stray
//    red_done ignored; next op opa=10, opb=10, m=13 -> out_y=9.
//  6 Back-to-back: 20 random ops, out_ready random -> every out_y equals
//    (opa*opb) mod m; no dropped or duplicated results.

Source files
------------

// File: rtl/modmul_front.sv
// modmul_front
// Front end of the Barrett reduction stage. It accepts an operand pair plus
// modulus, builds the full 2*NBITS product with a digit-serial
// multiply-accumulate (one DBITS digit of opb per cycle, most significant
// digit first), fires a one-cycle start pulse at the reducer and waits for its
// result. The residue is then held downstream until it is taken.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake; opa, opb, m latched on accept
//   red_start             one-cycle launch pulse to the reducer
//   red_a, red_m, red_mx3 product, modulus and 3*m presented to the reducer
//   red_done, red_y       reducer completion pulse and its result
//   out_valid/out_ready   result handshake; out_y carries opa*opb mod m
//   busy                  high whenever an operation is in flight
module modmul_front #(
    parameter int NBITS = 128,
    parameter int DBITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   opa,
    input  logic [NBITS-1:0]   opb,
    input  logic [NBITS-1:0]   m,
    output logic               red_start,
    output logic [2*NBITS-1:0] red_a,
    output logic [NBITS-1:0]   red_m,
    output logic [NBITS+1:0]   red_mx3,
    input  logic               red_done,
    input  logic [NBITS-1:0]   red_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NBITS-1:0]   out_y,
    output logic               busy
);

    localparam int NDIG = NBITS / DBITS;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_RED,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   opa_q, opa_d;
    logic [NBITS-1:0]   opb_q, opb_d;
    logic [2*NBITS-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*NBITS-1:0] red_a_q, red_a_d;
    logic [NBITS-1:0]   red_m_q, red_m_d;
    logic [NBITS+1:0]   red_mx3_q, red_mx3_d;
    logic               red_start_q, red_start_d;
    logic [NBITS-1:0]   out_y_q, out_y_d;
    logic               out_valid_q, out_valid_d;

    // Partial product of opa with the current top digit of opb, and the
    // accumulator after shifting in that digit's contribution.
    logic [NBITS+DBITS-1:0] part_prod;
    logic [2*NBITS-1:0]     mac_sum;

    // State register and all datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            red_a_q     <= '0;
            red_m_q     <= '0;
            red_mx3_q   <= '0;
            red_start_q <= 1'b0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            red_a_q     <= red_a_d;
            red_m_q     <= red_m_d;
            red_mx3_q   <= red_mx3_d;
            red_start_q <= red_start_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath logic. opb is shifted left each MULT cycle so
    // the digit being consumed is always its top DBITS bits.
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        red_a_d     = red_a_q;
        red_m_d     = red_m_q;
        red_mx3_d   = red_mx3_q;
        red_start_d = 1'b0;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;

        part_prod = {{DBITS{1'b0}}, opa_q} * {{NBITS{1'b0}}, opb_q[NBITS-1 -: DBITS]};
        mac_sum   = (acc_q << DBITS) + {{(NBITS-DBITS){1'b0}}, part_prod};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d     = opa;
                    opb_d     = opb;
                    red_m_d   = m;
                    red_mx3_d = {2'b00, m} + {1'b0, m, 1'b0};
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_MULT;
                end
            end
            S_MULT: begin
                acc_d = mac_sum;
                opb_d = opb_q << DBITS;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    red_a_d     = mac_sum;
                    red_start_d = 1'b1;
                    state_d     = S_RED;
                end
            end
            S_RED: begin
                if (red_done) begin
                    out_y_d     = red_y;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign red_start = red_start_q;
    assign red_a     = red_a_q;
    assign red_m     = red_m_q;
    assign red_mx3   = red_mx3_q;
    assign out_y     = out_y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_modmul_front.sv
// tb_modmul_front
// Drives modmul_front with directed and random operations. A small
// behavioural reducer answers red_start three cycles later with
// red_a mod red_m; expected residues come from plain wide arithmetic on the
// operands the bench itself chose.
module tb_modmul_front;

    localparam int NBITS = 128;
    localparam int DBITS = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [NBITS-1:0]   opa = '0;
    logic [NBITS-1:0]   opb = '0;
    logic [NBITS-1:0]   m = '0;
    logic               in_ready;
    logic               red_start;
    logic [2*NBITS-1:0] red_a;
    logic [NBITS-1:0]   red_m;
    logic [NBITS+1:0]   red_mx3;
    logic               red_done;
    logic [NBITS-1:0]   red_y;
    logic               out_valid;
    logic [NBITS-1:0]   out_y;
    logic               busy;

    int n_cmp = 0;
    int n_fail = 0;

    modmul_front #(.NBITS(NBITS), .DBITS(DBITS)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .opa(opa),
        .opb(opb),
        .m(m),
        .red_start(red_start),
        .red_a(red_a),
        .red_m(red_m),
        .red_mx3(red_mx3),
        .red_done(red_done),
        .red_y(red_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y(out_y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural reducer: start seen at edge E, done pulse sampled at E+3.
    logic               model_done = 1'b0;
    logic [NBITS-1:0]   model_y = '0;
    logic [2*NBITS-1:0] rd_a = '0;
    logic [NBITS-1:0]   rd_m = '0;
    int                 rd_cnt = 0;
    logic [2*NBITS-1:0] rd_mod;
    logic               stray_done = 1'b0;
    logic [NBITS-1:0]   stray_y = '0;

    assign rd_mod   = (rd_m == '0) ? '0 : rd_a % {128'd0, rd_m};
    assign red_done = model_done | stray_done;
    assign red_y    = stray_done ? stray_y : model_y;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (red_start) begin
            rd_a   <= red_a;
            rd_m   <= red_m;
            rd_cnt <= 1;
        end else if (rd_cnt == 1) begin
            rd_cnt <= 2;
        end else if (rd_cnt == 2) begin
            model_done <= 1'b1;
            model_y    <= rd_mod[NBITS-1:0];
            rd_cnt     <= 0;
        end
    end

    // Observes launch pulses and what was presented alongside them.
    int                 start_total = 0;
    logic [2*NBITS-1:0] cap_a = '0;
    logic [NBITS+1:0]   cap_mx3 = '0;

    always @(negedge clk) begin
        if (red_start) begin
            start_total = start_total + 1;
            cap_a       = red_a;
            cap_mx3     = red_mx3;
        end
    end

    function automatic logic [NBITS-1:0] ref_mod(input logic [NBITS-1:0] a,
                                                 input logic [NBITS-1:0] b,
                                                 input logic [NBITS-1:0] mm);
        logic [2*NBITS-1:0] p;
        p = {128'd0, a} * {128'd0, b};
        p = p % {128'd0, mm};
        return p[NBITS-1:0];
    endfunction

    function automatic logic [NBITS-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [2*NBITS-1:0] obs,
                               input logic [2*NBITS-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                 input logic [NBITS-1:0] mm);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("in_ready_wait", {255'd0, in_ready}, 256'd1);
        opa      = a;
        opb      = b;
        m        = mm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("out_valid_wait", {255'd0, out_valid}, 256'd1);
    endtask

    initial begin
        int                 lat;
        int                 s0;
        logic [NBITS-1:0]   a, b, mm, exp_y;
        logic [NBITS-1:0]   exp_q[$];
        int                 issued, done;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("rst_busy", {255'd0, busy}, 256'd0);
        checkOutput("rst_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("rst_red_start", {255'd0, red_start}, 256'd0);
        checkOutput("rst_red_a", red_a, 256'd0);
        checkOutput("rst_red_mx3", {126'd0, red_mx3}, 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // Small operands, latency and single launch pulse.
        s0 = start_total;
        applyStimulus(128'd3, 128'd5, 128'd7);
        waitValid(lat);
        checkOutput("s1_latency", 256'(lat), 256'd8);
        checkOutput("s1_out_y", {128'd0, out_y}, 256'd1);
        checkOutput("s1_red_a", cap_a, 256'd15);
        checkOutput("s1_red_mx3", {126'd0, cap_mx3}, 256'd21);
        checkOutput("s1_red_m", {128'd0, red_m}, 256'd7);
        checkOutput("s1_start_pulses", 256'(start_total - s0), 256'd1);
        checkOutput("s1_in_ready", {255'd0, in_ready}, 256'd0);
        checkOutput("s1_busy", {255'd0, busy}, 256'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("s1_released_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("s1_released_in_ready", {255'd0, in_ready}, 256'd1);

        // All-ones operands, out_ready held high so HOLD lasts one cycle.
        out_ready = 1'b1;
        a  = '1;
        mm = {1'b0, {127{1'b1}}};
        applyStimulus(a, a, mm);
        waitValid(lat);
        checkOutput("s2_red_a", cap_a, {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'd1});
        checkOutput("s2_out_y", {128'd0, out_y}, {128'd0, ref_mod(a, a, mm)});
        @(negedge clk);
        checkOutput("s2_hold_one_cycle", {255'd0, out_valid}, 256'd0);
        checkOutput("s2_busy", {255'd0, busy}, 256'd0);
        out_ready = 1'b0;

        // Back-pressure for 10 cycles.
        a = rand128(); b = rand128(); mm = rand128() | 128'd1;
        exp_y = ref_mod(a, b, mm);
        applyStimulus(a, b, mm);
        waitValid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("s3_valid_held", {255'd0, out_valid}, 256'd1);
            checkOutput("s3_y_held", {128'd0, out_y}, {128'd0, exp_y});
            checkOutput("s3_in_ready", {255'd0, in_ready}, 256'd0);
            checkOutput("s3_busy", {255'd0, busy}, 256'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("s3_idle_busy", {255'd0, busy}, 256'd0);
        checkOutput("s3_idle_in_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("s3_idle_valid", {255'd0, out_valid}, 256'd0);

        // in_valid pulsed with other operands while busy must be ignored.
        a = rand128(); b = rand128(); mm = rand128() | 128'd1;
        applyStimulus(a, b, mm);
        for (int i = 0; i < 7; i++) begin
            opa = rand128(); opb = rand128(); m = rand128() | 128'd1;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        waitValid(lat);
        checkOutput("s4_out_y", {128'd0, out_y}, {128'd0, ref_mod(a, b, mm)});
        checkOutput("s4_red_a", cap_a, {128'd0, a} * {128'd0, b});
        checkOutput("s4_red_m", {128'd0, red_m}, {128'd0, mm});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("s4_idle", {255'd0, busy}, 256'd0);

        // Reset in MULT cycle 2, stray red_done afterwards, then a clean op.
        applyStimulus(rand128(), rand128(), rand128() | 128'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("s5_in_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("s5_busy", {255'd0, busy}, 256'd0);
        checkOutput("s5_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("s5_red_start", {255'd0, red_start}, 256'd0);
        checkOutput("s5_red_a", red_a, 256'd0);
        checkOutput("s5_red_m", {128'd0, red_m}, 256'd0);
        checkOutput("s5_red_mx3", {126'd0, red_mx3}, 256'd0);
        checkOutput("s5_out_y", {128'd0, out_y}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        stray_y = 128'h55;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        checkOutput("s5_stray_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("s5_stray_busy", {255'd0, busy}, 256'd0);
        checkOutput("s5_stray_y", {128'd0, out_y}, 256'd0);
        applyStimulus(128'd10, 128'd10, 128'd13);
        waitValid(lat);
        checkOutput("s5_out_y", {128'd0, out_y}, 256'd9);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Random back-to-back traffic with random downstream back-pressure.
        issued = 0;
        done = 0;
        for (int cyc = 0; cyc < 3000 && done < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("s6_unexpected_result", {128'd0, out_y}, 256'd0);
                    checkOutput("s6_queue_empty", 256'd1, 256'd0);
                end else begin
                    exp_y = exp_q.pop_front();
                    checkOutput("s6_out_y", {128'd0, out_y}, {128'd0, exp_y});
                end
                done++;
            end
            if (issued < 20 && in_ready) begin
                a  = rand128();
                b  = rand128();
                mm = ($urandom_range(0, 3) == 0) ? 128'($urandom_range(1, 1000)) : (rand128() | 128'd1);
                opa = a; opb = b; m = mm;
                in_valid = 1'b1;
                exp_q.push_back(ref_mod(a, b, mm));
                issued++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("s6_results_done", 256'(done), 256'd20);
        checkOutput("s6_queue_drained", 256'(exp_q.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
